// File: rtl/sar_adc_ctrl_pkg.sv
// Shared types and defaults for the successive-approximation ADC controller.
package sar_adc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int DEFAULT_PRECISION     = 12;
   localparam int DEFAULT_SETTLE_CYCLES = 4;
   // Wide enough for the largest legal settle time (255).
   localparam int TIMER_W               = 8;

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Control/data bundle between a conversion requester (master) and the SAR controller (slave).
interface sar_adc_ctrl_if
   import sar_adc_ctrl_pkg::*;
#(
   parameter int PRECISION = DEFAULT_PRECISION
);

   // start is a level request sampled only while idle; abort is honoured only while
   // settling or comparing; done is a one-cycle pulse marking a new result; busy
   // spans start acceptance to the return to idle. No other handshake exists.
   logic                 start;
   logic                 abort;
   logic                 comp_in;
   logic [PRECISION-1:0] dac_code;
   logic [PRECISION-1:0] result;
   logic                 busy;
   logic                 done;
   state_t               state;

   modport master (
      output start, abort, comp_in,
      input  dac_code, result, busy, done, state
   );

   modport slave (
      input  start, abort, comp_in,
      output dac_code, result, busy, done, state
   );

endinterface

// File: rtl/sar_settle_timer.sv
// Loadable down-counter; expired flags the last clock of a settle window.
module sar_settle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_value,
   output logic         expired
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (en && count_q != '0) begin
         count_q <= count_q - W'(1);
      end
   end

   // Loading N and decrementing once per enabled clock makes the N-th clock the expiry.
   assign expired = (count_q == W'(1));

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: binary search of the DAC code against a comparator.
module sar_adc_ctrl
   import sar_adc_ctrl_pkg::*;
#(
   parameter int PRECISION     = DEFAULT_PRECISION,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
   input  logic          clk,
   input  logic          reset,
   sar_adc_ctrl_if.slave bus
);

   localparam int IDX_W = (PRECISION > 1) ? $clog2(PRECISION) : 1;

   state_t               state_q, state_n;
   logic [PRECISION-1:0] dac_q, dac_n;
   logic [PRECISION-1:0] result_q, result_n;
   logic                 busy_q, busy_n;
   logic                 done_q, done_n;
   logic [IDX_W-1:0]     idx_q, idx_n;
   logic [1:0]           comp_sync_q;
   logic                 comp_s;
   logic                 tmr_load, tmr_en, tmr_expired;
   logic [PRECISION-1:0] bit_mask;
   logic [PRECISION-1:0] code_kept;

   // comp_in is asynchronous to clk; the settle window absorbs these two flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) comp_sync_q <= 2'b00;
      else       comp_sync_q <= {comp_sync_q[0], bus.comp_in};
   end
   assign comp_s = comp_sync_q[1];

   sar_settle_timer #(.W(TIMER_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (tmr_load),
      .en         (tmr_en),
      .load_value (TIMER_W'(SETTLE_CYCLES)),
      .expired    (tmr_expired)
   );

   assign bit_mask  = PRECISION'(1) << idx_q;
   assign code_kept = comp_s ? dac_q : (dac_q & ~bit_mask);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_n;
   end

   always_comb begin
      state_n  = state_q;
      dac_n    = dac_q;
      result_n = result_q;
      busy_n   = busy_q;
      done_n   = 1'b0;
      idx_n    = idx_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            dac_n = '0;
            if (bus.start) begin
               state_n  = ST_SETTLE;
               busy_n   = 1'b1;
               idx_n    = IDX_W'(PRECISION - 1);
               dac_n    = PRECISION'(1) << (PRECISION - 1);
               tmr_load = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (bus.abort) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               dac_n   = '0;
            end else begin
               tmr_en = 1'b1;
               if (tmr_expired) state_n = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            // Abort takes priority over resolving the current bit.
            if (bus.abort) begin
               state_n = ST_IDLE;
               busy_n  = 1'b0;
               dac_n   = '0;
            end else if (idx_q != '0) begin
               dac_n    = code_kept | (bit_mask >> 1);
               idx_n    = idx_q - IDX_W'(1);
               tmr_load = 1'b1;
               state_n  = ST_SETTLE;
            end else begin
               dac_n    = code_kept;
               result_n = code_kept;
               state_n  = ST_DONE;
            end
         end
         ST_DONE: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            dac_n   = '0;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dac_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         idx_q    <= '0;
      end else begin
         dac_q    <= dac_n;
         result_q <= result_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         idx_q    <= idx_n;
      end
   end

   assign bus.dac_code = dac_q;
   assign bus.result   = result_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.state    = state_q;

endmodule
